// File: rtl/fnd_timer_display.sv
`default_nettype none
// ============================================================================
// Module      : fnd_timer_display
// Description : Scans a 4-digit common-anode 7-segment display from the game
//               countdown timer digits. Adds a blinking colon (digit 2 dp)
//               while running, a blinking warning display in the last 10 s,
//               and a blinking 0000 after time-over.
// Revision    : 1.0 - initial release
// ============================================================================
module fnd_timer_display #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int BLINK_HZ    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] min1,
    input  logic [3:0] min0,
    input  logic [3:0] sec1,
    input  logic [3:0] sec0,
    input  logic       time_over,
    input  logic       running,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_SCAN_DIV   = CLK_FREQ_HZ / (4 * SCAN_HZ);
    localparam int c_BLINK_HALF = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int c_SCAN_W     = (c_SCAN_DIV  > 2) ? $clog2(c_SCAN_DIV)  : 1;
    localparam int c_BLINK_W    = (c_BLINK_HALF > 2) ? $clog2(c_BLINK_HALF) : 1;

    localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(c_SCAN_DIV - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(c_BLINK_HALF - 1);

    // Display modes, derived from the frame snapshot
    localparam logic [1:0] c_MODE_NORMAL = 2'd0;
    localparam logic [1:0] c_MODE_WARN   = 2'd1;
    localparam logic [1:0] c_MODE_OVER   = 2'd2;

    // Segment patterns {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] c_SEG_BLANK = 7'h7F;
    localparam logic [6:0] c_SEG_DASH  = 7'b0111111;

    // ------------------------------------------------------------------------
    // BCD to active-low segment decode; non-BCD codes show a dash
    // ------------------------------------------------------------------------
    function automatic logic [6:0] f_seg7(input logic [3:0] i_bcd);
        logic [6:0] v_seg;
        case (i_bcd)
            4'd0:    v_seg = 7'b1000000;
            4'd1:    v_seg = 7'b1111001;
            4'd2:    v_seg = 7'b0100100;
            4'd3:    v_seg = 7'b0110000;
            4'd4:    v_seg = 7'b0011001;
            4'd5:    v_seg = 7'b0010010;
            4'd6:    v_seg = 7'b0000010;
            4'd7:    v_seg = 7'b1111000;
            4'd8:    v_seg = 7'b0000000;
            4'd9:    v_seg = 7'b0010000;
            default: v_seg = c_SEG_DASH;
        endcase
        return v_seg;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_SCAN_W-1:0]  r_scan_cnt_q,    w_scan_cnt_d;
    logic [1:0]           r_digit_idx_q,   w_digit_idx_d;
    logic [c_BLINK_W-1:0] r_blink_cnt_q,   w_blink_cnt_d;
    logic                 r_blink_phase_q, w_blink_phase_d;

    logic [3:0]           r_snap_min1_q,   w_snap_min1_d;
    logic [3:0]           r_snap_min0_q,   w_snap_min0_d;
    logic [3:0]           r_snap_sec1_q,   w_snap_sec1_d;
    logic [3:0]           r_snap_sec0_q,   w_snap_sec0_d;
    logic                 r_snap_over_q,   w_snap_over_d;
    logic                 r_snap_run_q,    w_snap_run_d;

    logic [3:0]           r_fnd_com_q,     w_fnd_com_d;
    logic [7:0]           r_fnd_data_q,    w_fnd_data_d;

    logic                 w_scan_wrap;
    logic                 w_frame_end;
    logic                 w_blink_wrap;

    logic [1:0]           w_mode;
    logic [3:0]           w_digit_val;
    logic [6:0]           w_seg;
    logic                 w_dp_n;
    logic                 w_blank;
    logic                 w_colon_n;

    // Digit scan counter and index; a frame ends when digit 3 finishes
    always_comb begin
        w_scan_wrap   = (r_scan_cnt_q == c_SCAN_LAST);
        w_frame_end   = w_scan_wrap && (r_digit_idx_q == 2'd3);
        w_scan_cnt_d  = w_scan_wrap ? '0 : r_scan_cnt_q + 1'b1;
        w_digit_idx_d = w_scan_wrap ? r_digit_idx_q + 2'd1 : r_digit_idx_q;
    end

    // Free-running blink phase generator
    always_comb begin
        w_blink_wrap    = (r_blink_cnt_q == c_BLINK_LAST);
        w_blink_cnt_d   = w_blink_wrap ? '0 : r_blink_cnt_q + 1'b1;
        w_blink_phase_d = w_blink_wrap ? ~r_blink_phase_q : r_blink_phase_q;
    end

    // Capture the inputs once per frame so a frame never mixes two times
    always_comb begin
        w_snap_min1_d = r_snap_min1_q;
        w_snap_min0_d = r_snap_min0_q;
        w_snap_sec1_d = r_snap_sec1_q;
        w_snap_sec0_d = r_snap_sec0_q;
        w_snap_over_d = r_snap_over_q;
        w_snap_run_d  = r_snap_run_q;
        if (w_frame_end) begin
            w_snap_min1_d = min1;
            w_snap_min0_d = min0;
            w_snap_sec1_d = sec1;
            w_snap_sec0_d = sec0;
            w_snap_over_d = time_over;
            w_snap_run_d  = running;
        end
    end

    // Display mode from the snapshot; time-over outranks the warning window
    always_comb begin
        w_mode = c_MODE_NORMAL;
        if (r_snap_over_q) begin
            w_mode = c_MODE_OVER;
        end else if ((r_snap_min1_q == 4'd0) && (r_snap_min0_q == 4'd0) &&
                     (r_snap_sec1_q == 4'd0)) begin
            w_mode = c_MODE_WARN;
        end
    end

    // Segment, dp and blanking for the digit currently selected by the index
    always_comb begin
        case (r_digit_idx_q)
            2'd0:    w_digit_val = r_snap_sec0_q;
            2'd1:    w_digit_val = r_snap_sec1_q;
            2'd2:    w_digit_val = r_snap_min0_q;
            default: w_digit_val = r_snap_min1_q;
        endcase

        // Colon: blinks while running, steady when paused
        w_colon_n = r_snap_run_q ? ~r_blink_phase_q : 1'b0;

        w_seg   = f_seg7(w_digit_val);
        w_dp_n  = 1'b1;
        w_blank = 1'b0;

        case (w_mode)
            c_MODE_OVER: begin
                w_seg   = f_seg7(4'd0);
                w_blank = ~r_blink_phase_q;
            end
            c_MODE_WARN: begin
                w_blank = ~r_blink_phase_q;
                if (r_digit_idx_q == 2'd2) begin
                    w_dp_n = w_colon_n;
                end
            end
            default: begin
                if ((r_digit_idx_q == 2'd3) && (r_snap_min1_q == 4'd0)) begin
                    w_seg = c_SEG_BLANK;
                end
                if (r_digit_idx_q == 2'd2) begin
                    w_dp_n = w_colon_n;
                end
            end
        endcase

        w_fnd_com_d  = ~(4'b0001 << r_digit_idx_q);
        w_fnd_data_d = w_blank ? 8'hFF : {w_dp_n, w_seg};
    end

    // All state registers, including the registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt_q    <= '0;
            r_digit_idx_q   <= 2'd0;
            r_blink_cnt_q   <= '0;
            r_blink_phase_q <= 1'b0;
            r_snap_min1_q   <= 4'd1;
            r_snap_min0_q   <= 4'd0;
            r_snap_sec1_q   <= 4'd0;
            r_snap_sec0_q   <= 4'd0;
            r_snap_over_q   <= 1'b0;
            r_snap_run_q    <= 1'b0;
            r_fnd_com_q     <= 4'b1111;
            r_fnd_data_q    <= 8'hFF;
        end else begin
            r_scan_cnt_q    <= w_scan_cnt_d;
            r_digit_idx_q   <= w_digit_idx_d;
            r_blink_cnt_q   <= w_blink_cnt_d;
            r_blink_phase_q <= w_blink_phase_d;
            r_snap_min1_q   <= w_snap_min1_d;
            r_snap_min0_q   <= w_snap_min0_d;
            r_snap_sec1_q   <= w_snap_sec1_d;
            r_snap_sec0_q   <= w_snap_sec0_d;
            r_snap_over_q   <= w_snap_over_d;
            r_snap_run_q    <= w_snap_run_d;
            r_fnd_com_q     <= w_fnd_com_d;
            r_fnd_data_q    <= w_fnd_data_d;
        end
    end

    assign fnd_com  = r_fnd_com_q;
    assign fnd_data = r_fnd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fnd_timer_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_fnd_timer_display
// Description : Randomized scoreboard bench for fnd_timer_display. A model
//               process derives the expected display word for every clock
//               from elapsed time since reset; a monitor compares outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fnd_timer_display;

    localparam int c_CLK_FREQ_HZ = 4000;
    localparam int c_SCAN_HZ     = 100;
    localparam int c_BLINK_HZ    = 100;
    localparam int c_SCAN_DIV    = c_CLK_FREQ_HZ / (4 * c_SCAN_HZ);
    localparam int c_BLINK_HALF  = c_CLK_FREQ_HZ / (2 * c_BLINK_HZ);
    localparam int c_FRAME       = 4 * c_SCAN_DIV;

    logic       clk;
    logic       rst;
    logic [3:0] min1, min0, sec1, sec0;
    logic       time_over;
    logic       running;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    logic [11:0] exp_q[$];
    int          n_checks;
    int          n_errors;
    int          n_cycle;

    fnd_timer_display #(
        .CLK_FREQ_HZ (c_CLK_FREQ_HZ),
        .SCAN_HZ     (c_SCAN_HZ),
        .BLINK_HZ    (c_BLINK_HZ)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .min1      (min1),
        .min0      (min0),
        .sec1      (sec1),
        .sec0      (sec0),
        .time_over (time_over),
        .running   (running),
        .fnd_com   (fnd_com),
        .fnd_data  (fnd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Full 8-bit pattern {dp,g..a} of a digit value with dp dark
    function automatic logic [7:0] glyph(input logic [3:0] v);
        case (v)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    // Expected {com,data} given clocks elapsed since reset and the frame's time
    function automatic logic [11:0] expect_word(input int cyc,
                                                input logic [3:0] m1, input logic [3:0] m0,
                                                input logic [3:0] s1, input logic [3:0] s0,
                                                input logic ov, input logic run);
        int         pos;
        bit         lit_phase;
        bit         warn;
        logic [3:0] com;
        logic [7:0] data;
        logic [3:0] v;
        pos       = (cyc / c_SCAN_DIV) % 4;
        lit_phase = ((cyc / c_BLINK_HALF) % 2) == 1;
        com       = 4'b1111;
        com[pos]  = 1'b0;
        if (ov) begin
            data = lit_phase ? 8'hC0 : 8'hFF;
        end else begin
            warn = (m1 == 0) && (m0 == 0) && (s1 == 0);
            v = (pos == 0) ? s0 : (pos == 1) ? s1 : (pos == 2) ? m0 : m1;
            data = glyph(v);
            if (!warn && pos == 3 && m1 == 0) data = 8'hFF;
            if (pos == 2 && (!run || lit_phase)) data = data & 8'h7F;
            if (warn && !lit_phase) data = 8'hFF;
        end
        return {com, data};
    endfunction

    // Reference model: time since reset plus the time captured at frame ends
    initial begin
        int         cyc;
        logic [3:0] sm1, sm0, ss1, ss0;
        logic       sov, srun;
        cyc = 0;
        sm1 = 4'd1; sm0 = 4'd0; ss1 = 4'd0; ss0 = 4'd0; sov = 1'b0; srun = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.push_back({4'hF, 8'hFF});
                cyc = 0;
                sm1 = 4'd1; sm0 = 4'd0; ss1 = 4'd0; ss0 = 4'd0; sov = 1'b0; srun = 1'b0;
            end else begin
                exp_q.push_back(expect_word(cyc, sm1, sm0, ss1, ss0, sov, srun));
                cyc++;
                if (cyc % c_FRAME == 0) begin
                    sm1 = min1; sm0 = min0; ss1 = sec1; ss0 = sec0;
                    sov = time_over; srun = running;
                end
            end
        end
    end

    // Monitor: compare the outputs presented after each clock edge
    initial begin
        logic [11:0] e;
        n_cycle = 0;
        forever begin
            @(posedge clk);
            #1;
            n_cycle++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_empty cycle=%0d no expected entry", n_cycle);
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (fnd_com !== e[11:8]) begin
                    n_errors++;
                    $display("FAIL fnd_com cycle=%0d got=%b expected=%b", n_cycle, fnd_com, e[11:8]);
                end
                n_checks++;
                if (fnd_data !== e[7:0]) begin
                    n_errors++;
                    $display("FAIL fnd_data cycle=%0d com=%b got=%h expected=%h",
                             n_cycle, fnd_com, fnd_data, e[7:0]);
                end
            end
        end
    end

    task automatic set_in(input logic [3:0] m1, input logic [3:0] m0,
                          input logic [3:0] s1, input logic [3:0] s0,
                          input logic ov, input logic run);
        min1 = m1; min0 = m0; sec1 = s1; sec0 = s0;
        time_over = ov; running = run;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] rand_digit();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    // Stimulus
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        set_in(4'd1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        run_cycles(5);
        rst = 1'b0;
        run_cycles(200);

        set_in(4'd0, 4'd5, 4'd3, 4'd7, 1'b0, 1'b1);
        run_cycles(95);
        set_in(4'd0, 4'd5, 4'd3, 4'd6, 1'b0, 1'b1);
        run_cycles(160);

        set_in(4'd0, 4'd0, 4'd0, 4'd9, 1'b0, 1'b1);
        run_cycles(200);
        set_in(4'd0, 4'd0, 4'd0, 4'd9, 1'b0, 1'b0);
        run_cycles(120);

        set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        run_cycles(217);
        rst = 1'b1;
        run_cycles(1);
        rst = 1'b0;
        set_in(4'd1, 4'd2, 4'd4, 4'hC, 1'b0, 1'b1);
        run_cycles(180);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0)
                set_in(4'd0, 4'd0, 4'd0, rand_digit(), $urandom_range(0, 5) == 0,
                       1'($urandom_range(0, 1)));
            else
                set_in(rand_digit(), rand_digit(), rand_digit(), rand_digit(),
                       $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                run_cycles(int'($urandom_range(1, 3)));
                rst = 1'b0;
            end
            run_cycles(int'($urandom_range(5, 120)));
        end

        run_cycles(3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
